// File: rtl/ingress_pkt_buf.sv
// Store-and-forward ingress buffer ahead of mmu: packets are released only once
// fully buffered, at most one beat per GAP cycles; malformed/oversize/overflowing packets vanish whole.
module ingress_pkt_buf #(
  parameter int DATA_W     = 512,
  parameter int CTL_W      = 8,
  parameter int DEPTH_LOG2 = 5,
  parameter int MAX_BEATS  = 16,
  parameter int GAP        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CTL_W-1:0]  in_pkt_ctl,
  input  logic [DATA_W-1:0] in_pkt_data,
  output logic              out_valid_pkt_fifo,
  output logic [CTL_W-1:0]  out_pkt_ctl_fifo,
  output logic [DATA_W-1:0] out_pkt_data_fifo,
  output logic [15:0]       err_cnt,
  output logic [15:0]       drop_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int LW    = $clog2(MAX_BEATS + 1);
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CTL_W-1:0] C_SOP = CTL_W'(1);
  localparam logic [CTL_W-1:0] C_MID = CTL_W'(2);
  localparam logic [CTL_W-1:0] C_EOP = CTL_W'(3);
  localparam logic [CTL_W-1:0] C_ONE = CTL_W'(4);

  typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       wr_q, wr_d, commit_q, commit_d, rd_q, rd_d, base, waddr;
  logic [LW-1:0]       len_q, len_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [15:0]         err_q, err_d, drop_q, drop_d;
  logic                ov_q, ov_d;
  logic [CTL_W-1:0]    octl_q, octl_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic                we, err_inc, drop_inc, full;
  logic [CTL_W+DATA_W-1:0] mem [DEPTH];

  assign full = ((wr_q - rd_q) == PW'(DEPTH));

  // Write side: uncommitted beats live between commit_q and wr_q; rollback just rewinds wr.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    commit_d = commit_q;
    len_d    = len_q;
    we       = 1'b0;
    waddr    = wr_q;
    base     = wr_q;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    if (in_valid && in_pkt_ctl != '0) begin
      if (in_pkt_ctl > C_ONE) begin
        err_inc = 1'b1;
      end else if (in_pkt_ctl == C_SOP || in_pkt_ctl == C_ONE) begin
        // A new packet start aborts any open packet, then is handled as from IDLE.
        if (state_q == IN_PKT) begin
          base    = commit_q;
          err_inc = 1'b1;
        end
        wr_d = base;
        if ((base - rd_q) == PW'(DEPTH)) begin
          drop_inc = 1'b1;
          state_d  = (in_pkt_ctl == C_SOP) ? DISCARD : IDLE;
        end else begin
          we    = 1'b1;
          waddr = base;
          wr_d  = base + 1'b1;
          if (in_pkt_ctl == C_SOP) begin
            len_d   = LW'(1);
            state_d = IN_PKT;
          end else begin
            commit_d = base + 1'b1;
            state_d  = IDLE;
          end
        end
      end else begin
        case (state_q)
          IDLE:    err_inc = 1'b1;
          DISCARD: if (in_pkt_ctl == C_EOP) state_d = IDLE;
          default: begin
            if (full || len_q == LW'(MAX_BEATS)) begin
              wr_d     = commit_q;
              drop_inc = 1'b1;
              state_d  = (in_pkt_ctl == C_EOP) ? IDLE : DISCARD;
            end else begin
              we   = 1'b1;
              wr_d = wr_q + 1'b1;
              if (in_pkt_ctl == C_MID) begin
                len_d = len_q + 1'b1;
              end else begin
                commit_d = wr_q + 1'b1;
                state_d  = IDLE;
              end
            end
          end
        endcase
      end
    end
  end

  // Read side: only committed entries are visible; gap_q paces output beats.
  always_comb begin
    rd_d    = rd_q;
    gap_d   = gap_q;
    ov_d    = 1'b0;
    octl_d  = '0;
    odata_d = odata_q;
    if (rd_q != commit_q && gap_q == '0) begin
      ov_d              = 1'b1;
      {octl_d, odata_d} = mem[rd_q[DEPTH_LOG2-1:0]];
      rd_d              = rd_q + 1'b1;
      gap_d             = GW'(GAP - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  always_comb begin
    err_d  = (err_inc  && err_q  != 16'hFFFF) ? err_q  + 16'd1 : err_q;
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr[DEPTH_LOG2-1:0]] <= {in_pkt_ctl, in_pkt_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      err_q    <= '0;
      drop_q   <= '0;
      ov_q     <= 1'b0;
      octl_q   <= '0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      ov_q     <= ov_d;
      octl_q   <= octl_d;
      odata_q  <= odata_d;
    end
  end

  assign out_valid_pkt_fifo = ov_q;
  assign out_pkt_ctl_fifo   = octl_q;
  assign out_pkt_data_fifo  = odata_q;
  assign err_cnt            = err_q;
  assign drop_cnt           = drop_q;
endmodule

// File: tb/tb_ingress_pkt_buf.sv
// Directed bench: default-sized buffer (a_*) plus a 4-entry, GAP=8 buffer (b_*) for the full case.
module tb_ingress_pkt_buf;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         a_iv, a_ov, b_iv, b_ov;
  logic [7:0]   a_ic, a_oc, b_ic, b_oc;
  logic [511:0] a_id, a_od, b_id, b_od;
  logic [15:0]  a_err, a_drop, b_err, b_drop;

  ingress_pkt_buf dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_iv), .in_pkt_ctl(a_ic), .in_pkt_data(a_id),
    .out_valid_pkt_fifo(a_ov), .out_pkt_ctl_fifo(a_oc), .out_pkt_data_fifo(a_od),
    .err_cnt(a_err), .drop_cnt(a_drop)
  );

  ingress_pkt_buf #(.DEPTH_LOG2(2), .GAP(8)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_iv), .in_pkt_ctl(b_ic), .in_pkt_data(b_id),
    .out_valid_pkt_fifo(b_ov), .out_pkt_ctl_fifo(b_oc), .out_pkt_data_fifo(b_od),
    .err_cnt(b_err), .drop_cnt(b_drop)
  );

  typedef struct {
    int           cyc;
    logic [7:0]   ctl;
    logic [511:0] data;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t t;
    if (a_ov) begin
      t.cyc = cyc; t.ctl = a_oc; t.data = a_od;
      qa.push_back(t);
    end
  end

  always @(negedge clk) begin
    beat_t t;
    if (b_ov) begin
      t.cyc = cyc; t.ctl = b_oc; t.data = b_od;
      qb.push_back(t);
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [7:0] c, input logic [511:0] d);
    a_iv = 1'b1; a_ic = c; a_id = d;
    tick(1);
    a_iv = 1'b0; a_ic = 8'd0;
  endtask

  task automatic beat_b(input logic [7:0] c, input logic [511:0] d);
    b_iv = 1'b1; b_ic = c; b_id = d;
    tick(1);
    b_iv = 1'b0; b_ic = 8'd0;
  endtask

  logic [7:0] ec2 [4] = '{8'd1, 8'd2, 8'd2, 8'd3};

  initial begin
    a_iv = 1'b0; a_ic = 8'd0; a_id = '0;
    b_iv = 1'b0; b_ic = 8'd0; b_id = '0;
    tick(2);
    chk("rst_valid", 512'(a_ov), 512'(1'b0));
    chk("rst_ctl",   512'(a_oc), 512'(8'd0));
    chk("rst_data",  a_od, '0);
    chk("rst_err",   512'(a_err), 512'(16'd0));
    chk("rst_drop",  512'(a_drop), 512'(16'd0));
    reset = 1'b1;
    tick(1);

    // 1: single beat, latency 2 edges, one idle cycle behind it
    beat_a(8'd4, 512'hA5);
    chk("t1_early_valid", 512'(a_ov), 512'(1'b0));
    tick(1);
    chk("t1_valid", 512'(a_ov), 512'(1'b1));
    chk("t1_ctl",   512'(a_oc), 512'(8'd4));
    chk("t1_data",  a_od, 512'hA5);
    tick(1);
    chk("t1_gap_valid", 512'(a_ov), 512'(1'b0));
    chk("t1_gap_ctl",   512'(a_oc), 512'(8'd0));
    chk("t1_hold_data", a_od, 512'hA5);
    tick(3);
    qa.delete();

    // 2: four-beat packet released only after EOP, beats 2 cycles apart
    beat_a(8'd1, 512'd1);
    beat_a(8'd2, 512'd2);
    beat_a(8'd2, 512'd3);
    beat_a(8'd3, 512'd4);
    e = cyc;
    chk("t2_no_early_out", 512'(qa.size()), 512'(0));
    tick(10);
    chk("t2_count", 512'(qa.size()), 512'(4));
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      chk("t2_ctl",  512'(qa[i].ctl), 512'(ec2[i]));
      chk("t2_data", qa[i].data, 512'(i + 1));
      chk("t2_cyc",  512'(qa[i].cyc), 512'(e + 1 + 2 * i));
    end
    qa.delete();

    // 3: orphan EOP, then SOP restarted by a second SOP
    beat_a(8'd3, 512'h77);
    tick(4);
    chk("t3_err1", 512'(a_err), 512'(16'd1));
    chk("t3_no_out", 512'(qa.size()), 512'(0));
    beat_a(8'd1, 512'hA);
    beat_a(8'd1, 512'hB);
    beat_a(8'd3, 512'hC);
    e = cyc;
    tick(8);
    chk("t3_err2", 512'(a_err), 512'(16'd2));
    chk("t3_count", 512'(qa.size()), 512'(2));
    if (qa.size() == 2) begin
      chk("t3_ctl0",  512'(qa[0].ctl), 512'(8'd1));
      chk("t3_data0", qa[0].data, 512'hB);
      chk("t3_cyc0",  512'(qa[0].cyc), 512'(e + 1));
      chk("t3_ctl1",  512'(qa[1].ctl), 512'(8'd3));
      chk("t3_data1", qa[1].data, 512'hC);
    end
    qa.delete();

    // 4: 17-beat packet is oversize and dropped whole
    beat_a(8'd1, 512'd0);
    for (int i = 0; i < 15; i++) beat_a(8'd2, 512'(i + 1));
    beat_a(8'd3, 512'hEE);
    tick(4);
    chk("t4_drop", 512'(a_drop), 512'(16'd1));
    chk("t4_err",  512'(a_err), 512'(16'd2));
    chk("t4_no_out", 512'(qa.size()), 512'(0));
    beat_a(8'd4, 512'h44);
    e = cyc;
    tick(4);
    chk("t4_count", 512'(qa.size()), 512'(1));
    if (qa.size() == 1) begin
      chk("t4_ctl",  512'(qa[0].ctl), 512'(8'd4));
      chk("t4_data", qa[0].data, 512'h44);
      chk("t4_cyc",  512'(qa[0].cyc), 512'(e + 1));
    end
    qa.delete();

    // 5: 4-entry buffer; one single drains early, so the second middle beat finds it full
    beat_b(8'd4, 512'h10);
    e = cyc;
    beat_b(8'd4, 512'h11);
    beat_b(8'd4, 512'h12);
    beat_b(8'd1, 512'h20);
    beat_b(8'd2, 512'h21);
    beat_b(8'd2, 512'h22);
    beat_b(8'd3, 512'h23);
    tick(25);
    chk("t5_drop", 512'(b_drop), 512'(16'd1));
    chk("t5_err",  512'(b_err), 512'(16'd0));
    chk("t5_count", 512'(qb.size()), 512'(3));
    for (int i = 0; i < 3 && i < qb.size(); i++) begin
      chk("t5_ctl",  512'(qb[i].ctl), 512'(8'd4));
      chk("t5_data", qb[i].data, 512'(8'h10 + i));
      chk("t5_cyc",  512'(qb[i].cyc), 512'(e + 1 + 8 * i));
    end
    beat_b(8'd3, 512'h99);
    chk("t5_idle_after_eop", 512'(b_err), 512'(16'd1));
    tick(10);
    chk("t5_no_extra", 512'(qb.size()), 512'(3));

    // 6: reset mid-packet clears everything; partial packet never appears
    beat_a(8'd1, 512'h61);
    beat_a(8'd2, 512'h62);
    reset = 1'b0;
    #1;
    chk("t6_err",   512'(a_err), 512'(16'd0));
    chk("t6_drop",  512'(a_drop), 512'(16'd0));
    chk("t6_valid", 512'(a_ov), 512'(1'b0));
    chk("t6_data",  a_od, '0);
    tick(1);
    reset = 1'b1;
    tick(5);
    chk("t6_no_out", 512'(qa.size()), 512'(0));
    beat_a(8'd4, 512'h66);
    e = cyc;
    tick(3);
    chk("t6_count", 512'(qa.size()), 512'(1));
    if (qa.size() == 1) begin
      chk("t6_ctl",  512'(qa[0].ctl), 512'(8'd4));
      chk("t6_pdata", qa[0].data, 512'h66);
      chk("t6_cyc",  512'(qa[0].cyc), 512'(e + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
